store_align_buffer: RTL and testbench

//  Store-side counterpart of the load alignment unit in the MEM stage. Accepts SW/SWL/SWR/SH/SB

---
 rtl/mips_mem_pkg.sv | 23 ++
 rtl/store_align.sv | 52 +++++
 rtl/store_align_buffer.sv | 141 ++++++++++++++
 tb/tb_store_align_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage store path.
// Contents: store type codes, the full byte-enable mask and the store-buffer entry layout.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    ST_SW  = 3'd0,
    ST_SWL = 3'd1,
    ST_SWR = 3'd2,
    ST_SH  = 3'd3,
    ST_SB  = 3'd4
  } st_type_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // One queued store: word address, big-endian aligned data and byte enables.
  // be[3] covers bits 31:24, which is byte offset 0.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: maps a store type, a byte offset and the rt value
// onto big-endian byte lanes and a byte-enable mask.
// err flags a misaligned SW/SH or an unknown type code.
module store_align
  import mips_mem_pkg::*;
(
  input  logic [2:0]  st_type,
  input  logic [1:0]  st_offs,
  input  logic [31:0] st_data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        err
);

  // Decode the type and offset into lane data, enables and the error flag.
  always_comb begin
    wdata = 32'h0000_0000;
    be    = 4'b0000;
    err   = 1'b0;
    case (st_type)
      ST_SW: begin
        wdata = st_data;
        be    = BE_ALL;
        err   = (st_offs != 2'd0);
      end
      ST_SWL: begin
        // The most significant rt bytes go to the addressed byte and the ones after it.
        wdata = st_data >> {st_offs, 3'b000};
        be    = BE_ALL >> st_offs;
      end
      ST_SWR: begin
        // The least significant rt bytes go to the word start up to the addressed byte.
        wdata = st_data << {(2'd3 - st_offs), 3'b000};
        be    = BE_ALL << (2'd3 - st_offs);
      end
      ST_SH: begin
        wdata = {2{st_data[15:0]}};
        case (st_offs)
          2'd0:    be = 4'b1100;
          2'd2:    be = 4'b0011;
          default: err = 1'b1;
        endcase
      end
      ST_SB: begin
        wdata = {4{st_data[7:0]}};
        be    = 4'b1000 >> st_offs;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_align_buffer.sv
// MEM-stage store buffer: aligns incoming stores and queues up to DEPTH of them,
// draining the oldest to data memory over a req/ack handshake.
// Optional build macro: STORE_FWD_EN adds a youngest-match store-to-load forwarding port.
module store_align_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [2:0]               st_type,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_err,
  output logic                     mem_req,
  input  logic                     mem_ack,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef STORE_FWD_EN
  ,
  input  logic [31:0]              ld_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic [3:0]               fwd_be
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  st_entry_t       fifo_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            st_err_r;

  logic [31:0]     al_wdata_s;
  logic [3:0]      al_be_s;
  logic            al_err_s;
  logic            full_s;
  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  st_entry_t       head_s;

  store_align u_align (
    .st_type (st_type),
    .st_offs (st_addr[1:0]),
    .st_data (st_data),
    .wdata   (al_wdata_s),
    .be      (al_be_s),
    .err     (al_err_s)
  );

  assign full_s   = (count_r == CW'(DEPTH));
  // A bad store still completes its handshake; it is simply not enqueued.
  assign accept_s = st_valid && !full_s;
  assign push_s   = accept_s && !al_err_s;
  // An ack only counts while there is a head entry to take.
  assign pop_s    = (count_r != CW'(0)) && mem_ack;
  assign head_s   = fifo_r[rd_ptr_r];

  // FIFO storage, pointers, occupancy and the error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      st_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= '{addr: st_addr[31:2], wdata: al_wdata_s, be: al_be_s};
        wr_ptr_r         <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      st_err_r <= accept_s && al_err_s;
    end
  end

  // Head presentation; the fields read zero whenever no entry is pending.
  always_comb begin
    if (count_r != CW'(0)) begin
      mem_addr  = {head_s.addr, 2'b00};
      mem_wdata = head_s.wdata;
      mem_be    = head_s.be;
    end else begin
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
      mem_be    = 4'b0000;
    end
  end

  assign mem_req  = (count_r != CW'(0));
  assign count    = count_r;
  assign empty    = (count_r == CW'(0));
  assign full     = full_s;
  assign st_ready = !full_s;
  assign st_err   = st_err_r;

`ifdef STORE_FWD_EN
  logic [AW-1:0] fwd_idx_s;
  logic          unused_ld_s;

  assign unused_ld_s = ^ld_addr[1:0];

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = 32'h0000_0000;
    fwd_be    = 4'b0000;
    fwd_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx_s = rd_ptr_r + AW'(i);
      if ((CW'(i) < count_r) && (fifo_r[fwd_idx_s].addr == ld_addr[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_r[fwd_idx_s].wdata;
        fwd_be   = fifo_r[fwd_idx_s].be;
      end else begin
        // This entry is invalid or at another word address; keep the previous result.
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench for store_align_buffer: a scoreboard queue models the buffer,
// and a negedge monitor compares every observable output each cycle.
// Forwarding checks are active when STORE_FWD_EN is defined.
module tb_store_align_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_err;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;
  logic        empty;
  logic        full;
`ifdef STORE_FWD_EN
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_be;
`endif

  always #5 clk = ~clk;

  store_align_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_type   (st_type),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_err    (st_err),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef STORE_FWD_EN
    ,
    .ld_addr   (ld_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .fwd_be    (fwd_be)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-lane reference: lane 0 is memory byte offset 0 = bits 31:24 = be[3].
  function automatic void ref_store(input logic [2:0] t, input logic [31:0] a,
                                    input logic [31:0] rt, output exp_t e, output logic err);
    logic [7:0] lane [4];
    logic [7:0] rtb  [4];
    logic [3:0] en;
    int k;
    k   = int'(a[1:0]);
    err = 1'b0;
    en  = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      lane[j] = 8'h00;
      rtb[j]  = rt[31-8*j -: 8];
    end
    case (t)
      3'd0: begin
        if (k == 0) begin
          for (int j = 0; j < 4; j++) begin lane[j] = rtb[j]; en[3-j] = 1'b1; end
        end else err = 1'b1;
      end
      3'd1: for (int j = 0; j + k < 4; j++) begin lane[k+j] = rtb[j]; en[3-(k+j)] = 1'b1; end
      3'd2: for (int j = 0; j <= k; j++) begin lane[j] = rtb[3-k+j]; en[3-j] = 1'b1; end
      3'd3: begin
        for (int j = 0; j < 4; j += 2) begin lane[j] = rtb[2]; lane[j+1] = rtb[3]; end
        if (k == 0 || k == 2) begin en[3-k] = 1'b1; en[2-k] = 1'b1; end
        else err = 1'b1;
      end
      3'd4: begin
        for (int j = 0; j < 4; j++) lane[j] = rtb[3];
        en[3-k] = 1'b1;
      end
      default: err = 1'b1;
    endcase
    e.addr  = {a[31:2], 2'b00};
    e.be    = en;
    e.wdata = {lane[0], lane[1], lane[2], lane[3]};
  endfunction

  // Monitor: compare against the model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic err;
    logic acc;
    chk("st_err", {31'd0, st_err}, {31'd0, exp_err});
    chk("count", {29'd0, count}, sb_q.size());
    chk("empty", {31'd0, empty}, {31'd0, sb_q.size() == 0});
    chk("full", {31'd0, full}, {31'd0, sb_q.size() == DEPTH});
    chk("st_ready", {31'd0, st_ready}, {31'd0, sb_q.size() < DEPTH});
    chk("mem_req", {31'd0, mem_req}, {31'd0, sb_q.size() > 0});
    if (sb_q.size() > 0) begin
      chk("mem_addr", mem_addr, sb_q[0].addr);
      chk("mem_wdata", mem_wdata, sb_q[0].wdata);
      chk("mem_be", {28'd0, mem_be}, {28'd0, sb_q[0].be});
    end
`ifdef STORE_FWD_EN
    begin : fwd_model
      exp_t f;
      logic hit;
      hit = 1'b0;
      f   = '{addr: 32'd0, wdata: 32'd0, be: 4'd0};
      for (int i = sb_q.size() - 1; i >= 0 && !hit; i--) begin
        if (sb_q[i].addr[31:2] == ld_addr[31:2]) begin hit = 1'b1; f = sb_q[i]; end
      end
      chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, hit});
      chk("fwd_data", fwd_data, f.wdata);
      chk("fwd_be", {28'd0, fwd_be}, {28'd0, f.be});
    end
`endif
    if (!rst_n) begin
      sb_q.delete();
      exp_err = 1'b0;
    end else begin
      acc = st_valid && (sb_q.size() < DEPTH);
      ref_store(st_type, st_addr, st_data, e, err);
      exp_err = acc && err;
      if (mem_ack && sb_q.size() > 0) void'(sb_q.pop_front());
      if (acc && !err) sb_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_type = t; st_addr = a; st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_type = 3'd0; st_addr = 32'd0; st_data = 32'd0;
    mem_ack = 1'b0;
`ifdef STORE_FWD_EN
    ld_addr = 32'd0;
`endif
    step(); step();
    rst_n = 1'b1;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // SWL at offset 1
    issue(3'd1, 32'h0000_0101, 32'hAABB_CCDD);
    chk("swl_addr", mem_addr, 32'h0000_0100);
    chk("swl_wdata", mem_wdata, 32'h00AA_BBCC);
    chk("swl_be", {28'd0, mem_be}, 32'h7);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;

    // SWR at offset 2, then SB at offset 3
    issue(3'd2, 32'h0000_0102, 32'hAABB_CCDD);
    issue(3'd4, 32'h0000_0203, 32'h0000_0012);
    chk("swr_wdata", mem_wdata, 32'hBBCC_DD00);
    chk("swr_be", {28'd0, mem_be}, 32'hE);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("sb_wdata", mem_wdata, 32'h1212_1212);
    chk("sb_be", {28'd0, mem_be}, 32'h1);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;

    // Fill to full with ack held low, then overlap pushes and pops
    for (int i = 0; i < 4; i++) issue(3'd0, 32'h0000_0400 + 32'(4 * i), $urandom);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_ready", {31'd0, st_ready}, 32'd0);
    chk("full_head", mem_addr, 32'h0000_0400);
    st_valid = 1'b1; st_type = 3'd0; st_addr = 32'h0000_0500; st_data = $urandom;
    mem_ack = 1'b1; step();
    chk("full_ack_pop_only", {29'd0, count}, 32'd3);
    step();
    chk("push_pop_same", {29'd0, count}, 32'd3);
    mem_ack = 1'b0; step();
    st_valid = 1'b0;
    chk("refill", {29'd0, count}, 32'd4);
    mem_ack = 1'b1; repeat (5) step(); mem_ack = 1'b0;

    // Misaligned and aligned halfword/word handling
    issue(3'd0, 32'h0000_0102, 32'h1111_1111);
    chk("sw_mis_err", {31'd0, st_err}, 32'd1);
    chk("sw_mis_count", {29'd0, count}, 32'd0);
    issue(3'd3, 32'h0000_0101, 32'h0000_1234);
    chk("sh_odd_err", {31'd0, st_err}, 32'd1);
    issue(3'd3, 32'h0000_0102, 32'h0000_1234);
    chk("sh_ok_err", {31'd0, st_err}, 32'd0);
    chk("sh_be", {28'd0, mem_be}, 32'h3);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    issue(3'd6, 32'h0000_0100, 32'h0);
    chk("illegal_err", {31'd0, st_err}, 32'd1);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) issue(3'd4, 32'h0000_0600 + 32'(i), $urandom);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_be", {28'd0, mem_be}, 32'd0);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("late_ack_count", {29'd0, count}, 32'd0);

`ifdef STORE_FWD_EN
    issue(3'd4, 32'h0000_0300, 32'h0000_0011);
    issue(3'd4, 32'h0000_0301, 32'h0000_0022);
    ld_addr = 32'h0000_0302; #1;
    chk("fwd_hit_dir", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_be_dir", {28'd0, fwd_be}, 32'h4);
    chk("fwd_data_dir", fwd_data, 32'h2222_2222);
    mem_ack = 1'b1; step(); step(); mem_ack = 1'b0;
`endif

    // Randomized traffic; ack probability varies by phase to hit full and empty often
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 200; c++) begin
        rst_n    = ($urandom_range(0, 149) != 0);
        st_valid = ($urandom_range(0, 2) != 0);
        st_type  = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        st_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        st_data  = $urandom;
        mem_ack  = ($urandom_range(0, 3) < ph);
`ifdef STORE_FWD_EN
        ld_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
`endif
        step();
      end
    end
    st_valid = 1'b0; mem_ack = 1'b1; rst_n = 1'b1;
    repeat (6) step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
